// File: rtl/census_pkg.sv
// Shared widths, constants and the (cost, index) candidate type for the
// census winner-take-all disparity block.
package census_pkg;

  localparam int unsigned CODE_W      = 64;
  localparam int unsigned MAX_DISP    = 16;
  localparam int unsigned ROW_W       = 11;
  localparam int unsigned COL_W       = 11;
  localparam int unsigned COST_THRESH = 20;

  // A full popcount needs one bit more than log2 so that CODE_W itself fits
  function automatic int unsigned cost_width(input int unsigned code_w);
    return $clog2(code_w) + 1;
  endfunction

  localparam int unsigned COST_W       = cost_width(CODE_W);
  localparam int unsigned DISP_W       = $clog2(MAX_DISP);
  localparam int unsigned INVALID_COST = CODE_W + 1;
  localparam int unsigned NODES        = 2 * MAX_DISP - 1;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [COST_W-1:0] cost_t;
  typedef logic [DISP_W-1:0] disp_t;

  typedef struct packed {
    cost_t cost;
    disp_t idx;
  } cand_t;

endpackage

// File: rtl/census_stereo_wta_if.sv
// Census code input bus and disparity result bus of census_stereo_wta.
interface census_stereo_wta_if;
  import census_pkg::*;

  logic             census_valid;
  code_t            census_l;
  code_t            census_r;
  logic [ROW_W-1:0] center_row;
  logic [COL_W-1:0] center_col;

  logic             disp_valid;
  disp_t            disp;
  cost_t            cost;
  logic             disp_ok;
  logic [ROW_W-1:0] disp_row;
  logic [COL_W-1:0] disp_col;

  modport master (
    output census_valid, census_l, census_r, center_row, center_col,
    input  disp_valid, disp, cost, disp_ok, disp_row, disp_col
  );

  modport slave (
    input  census_valid, census_l, census_r, center_row, center_col,
    output disp_valid, disp, cost, disp_ok, disp_row, disp_col
  );

endinterface

// File: rtl/census_popcount.sv
// Combinational population count of one census XOR word.
module census_popcount
  import census_pkg::*;
(
  input  code_t code,
  output cost_t ones_c
);

  always_comb begin
    ones_c = '0;
    for (int unsigned i = 0; i < CODE_W; i++) begin
      ones_c = ones_c + COST_W'(code[i]);
    end
  end

endmodule

// File: rtl/census_stereo_wta.sv
// Per-pixel Hamming cost against MAX_DISP right-code candidates on the same
// row, followed by a pipelined winner-take-all min-tree.
module census_stereo_wta
  import census_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  census_stereo_wta_if.slave  bus
);

  // valid/coord stages: captured inputs, leaves, then one per tree level
  localparam int unsigned PIPE = DISP_W + 2;

  code_t            hist_q [MAX_DISP];
  code_t            hist_d [MAX_DISP];
  code_t            left_q, left_d;
  logic [MAX_DISP-1:0] mask_q, mask_d;
  disp_t            fill_q, fill_d;
  logic [PIPE-1:0]  vld_q, vld_d;
  logic [ROW_W-1:0] row_q [PIPE];
  logic [ROW_W-1:0] row_d [PIPE];
  logic [COL_W-1:0] col_q [PIPE];
  logic [COL_W-1:0] col_d [PIPE];
  cand_t            tree_q [NODES];
  cand_t            tree_d [NODES];
  cost_t            pop_c  [MAX_DISP];

  logic             disp_valid_q, disp_valid_d;
  disp_t            disp_q, disp_d;
  cost_t            cost_q, cost_d;
  logic             disp_ok_q, disp_ok_d;
  logic [ROW_W-1:0] disp_row_q, disp_row_d;
  logic [COL_W-1:0] disp_col_q, disp_col_d;

  // After the shift, hist[d] holds exactly candidate d of the captured pixel
  for (genvar g = 0; g < MAX_DISP; g++) begin : g_pop
    census_popcount u_pop (
      .code   (left_q ^ hist_q[g]),
      .ones_c (pop_c[g])
    );
  end

  always_comb begin
    hist_d       = hist_q;
    left_d       = left_q;
    mask_d       = mask_q;
    fill_d       = fill_q;
    vld_d        = {vld_q[PIPE-2:0], bus.census_valid};
    row_d        = row_q;
    col_d        = col_q;
    tree_d       = tree_q;
    disp_valid_d = vld_q[PIPE-1];
    disp_d       = disp_q;
    cost_d       = cost_q;
    disp_ok_d    = disp_ok_q;
    disp_row_d   = disp_row_q;
    disp_col_d   = disp_col_q;

    row_d[0] = bus.center_row;
    col_d[0] = bus.center_col;
    for (int unsigned p = 1; p < PIPE; p++) begin
      row_d[p] = row_q[p-1];
      col_d[p] = col_q[p-1];
    end

    if (bus.census_valid) begin
      hist_d[0] = bus.census_r;
      for (int unsigned k = 1; k < MAX_DISP; k++) begin
        hist_d[k] = hist_q[k-1];
      end
      left_d = bus.census_l;
      if (bus.center_col == '0) begin
        fill_d = '0;
      end else if (fill_q != DISP_W'(MAX_DISP - 1)) begin
        fill_d = fill_q + DISP_W'(1);
      end
      for (int unsigned d = 0; d < MAX_DISP; d++) begin
        mask_d[d] = (DISP_W'(d) <= fill_d);
      end
    end

    // Leaves: candidates beyond the row start can never win
    for (int unsigned d = 0; d < MAX_DISP; d++) begin
      tree_d[d].cost = mask_q[d] ? pop_c[d] : COST_W'(INVALID_COST);
      tree_d[d].idx  = DISP_W'(d);
    end

    // Node n's children sit at 2*(n-MAX_DISP); lower index wins ties
    for (int unsigned n = MAX_DISP; n < NODES; n++) begin
      if (tree_q[2*(n-MAX_DISP)+1].cost < tree_q[2*(n-MAX_DISP)].cost) begin
        tree_d[n] = tree_q[2*(n-MAX_DISP)+1];
      end else begin
        tree_d[n] = tree_q[2*(n-MAX_DISP)];
      end
    end

    if (vld_q[PIPE-1]) begin
      disp_d     = tree_q[NODES-1].idx;
      cost_d     = tree_q[NODES-1].cost;
      disp_ok_d  = (tree_q[NODES-1].cost <= COST_W'(COST_THRESH));
      disp_row_d = row_q[PIPE-1];
      disp_col_d = col_q[PIPE-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < MAX_DISP; k++) hist_q[k] <= '0;
      for (int unsigned n = 0; n < NODES; n++)    tree_q[n] <= '0;
      for (int unsigned p = 0; p < PIPE; p++) begin
        row_q[p] <= '0;
        col_q[p] <= '0;
      end
      left_q       <= '0;
      mask_q       <= '0;
      fill_q       <= '0;
      vld_q        <= '0;
      disp_valid_q <= 1'b0;
      disp_q       <= '0;
      cost_q       <= '0;
      disp_ok_q    <= 1'b0;
      disp_row_q   <= '0;
      disp_col_q   <= '0;
    end else begin
      hist_q       <= hist_d;
      tree_q       <= tree_d;
      row_q        <= row_d;
      col_q        <= col_d;
      left_q       <= left_d;
      mask_q       <= mask_d;
      fill_q       <= fill_d;
      vld_q        <= vld_d;
      disp_valid_q <= disp_valid_d;
      disp_q       <= disp_d;
      cost_q       <= cost_d;
      disp_ok_q    <= disp_ok_d;
      disp_row_q   <= disp_row_d;
      disp_col_q   <= disp_col_d;
    end
  end

  assign bus.disp_valid = disp_valid_q;
  assign bus.disp       = disp_q;
  assign bus.cost       = cost_q;
  assign bus.disp_ok    = disp_ok_q;
  assign bus.disp_row   = disp_row_q;
  assign bus.disp_col   = disp_col_q;

endmodule

// File: tb/tb_census_stereo_wta.sv
// Scoreboard bench for census_stereo_wta: a row-level reference model queues
// expected results; a monitor matches them against the output stream.
module tb_census_stereo_wta;
  import census_pkg::*;

  localparam int unsigned LATENCY = DISP_W + 2;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;

  census_stereo_wta_if bus ();

  census_stereo_wta dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint disp;
    longint cost;
    longint ok;
    longint row;
    longint col;
    longint due;
  } exp_t;

  exp_t  exp_q [$];
  code_t rh [$];      // right codes of recent accepts, newest first
  int    fill_m;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  function automatic code_t rnd_code();
    return {$urandom, $urandom};
  endfunction

  function automatic code_t flip_k(input int k);
    code_t m = '0;
    while ($countones(m) < k) m[$urandom_range(CODE_W-1, 0)] = 1'b1;
    return m;
  endfunction

  function automatic void model_reset();
    rh.delete();
    repeat (MAX_DISP) rh.push_back('0);
    fill_m = 0;
    exp_q.delete();
  endfunction

  // Reference: candidate d is the right code from d accepts ago, usable only
  // if d is within the distance from the row start (capped).
  function automatic void model_accept(input code_t l, input code_t r,
                                       input int row, input int col);
    exp_t e;
    int   best_c;
    int   best_d;
    rh.push_front(r);
    void'(rh.pop_back());
    if (col == 0) fill_m = 0;
    else fill_m = (fill_m + 1 > int'(MAX_DISP) - 1) ? int'(MAX_DISP) - 1 : fill_m + 1;
    best_c = int'(INVALID_COST);
    best_d = 0;
    for (int d = 0; d <= fill_m; d++) begin
      if ($countones(l ^ rh[d]) < best_c) begin
        best_c = $countones(l ^ rh[d]);
        best_d = d;
      end
    end
    e.disp = best_d;
    e.cost = best_c;
    e.ok   = (best_c <= int'(COST_THRESH)) ? 1 : 0;
    e.row  = row;
    e.col  = col;
    e.due  = cyc + 1 + LATENCY;
    exp_q.push_back(e);
  endfunction

  task automatic send(input code_t l, input code_t r, input int row, input int col);
    @(negedge clk);
    bus.census_valid = 1'b1;
    bus.census_l     = l;
    bus.census_r     = r;
    bus.center_row   = ROW_W'(row);
    bus.center_col   = COL_W'(col);
    model_accept(l, r, row, col);
    @(posedge clk);
    #1 bus.census_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, longint'(bus.disp_valid), 0);
    check({tag, "_disp"},  longint'(bus.disp),       0);
    check({tag, "_cost"},  longint'(bus.cost),       0);
    check({tag, "_ok"},    longint'(bus.disp_ok),    0);
    check({tag, "_row"},   longint'(bus.disp_row),   0);
    check({tag, "_col"},   longint'(bus.disp_col),   0);
  endtask

  // Monitor: every disp_valid must match the oldest expectation, on time
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.disp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got disp_valid=1 expected none (cyc %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc, e.due);
          check("disp",    longint'(bus.disp),     e.disp);
          check("cost",    longint'(bus.cost),     e.cost);
          check("disp_ok", longint'(bus.disp_ok),  e.ok);
          check("row",     longint'(bus.disp_row), e.row);
          check("col",     longint'(bus.disp_col), e.col);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_valid: got none expected result col %0d due cyc %0d (cyc %0d)",
                 e.col, e.due, cyc);
      end
    end
  end

  initial begin : stim
    code_t lc [$];
    code_t l_tgt;
    code_t r;
    int    gap;

    bus.census_valid = 1'b0;
    bus.census_l     = '0;
    bus.census_r     = '0;
    bus.center_row   = '0;
    bus.center_col   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(negedge clk);
    #2 rst = 1'b0;

    // identical left/right codes over a 320-pixel row
    for (int c = 0; c < 320; c++) begin
      l_tgt = rnd_code();
      send(l_tgt, l_tgt, 1, c);
    end

    // right stream is the left stream shifted by 5 columns
    lc.delete();
    for (int c = 0; c < 70; c++) lc.push_back(rnd_code());
    for (int c = 0; c < 64; c++) send(lc[c], lc[c+5], 2, c);

    // short row start, then a fresh row must ignore the old codes
    lc.delete();
    for (int c = 0; c < 9; c++) lc.push_back(rnd_code());
    for (int c = 0; c < 4; c++) send(lc[c], lc[c+5], 3, c);
    send(rnd_code(), rnd_code(), 4, 0);
    send(rnd_code(), rnd_code(), 4, 1);

    // tie at col 10: d=2 and d=7 both cost 3, the rest cost more
    l_tgt = rnd_code();
    for (int c = 0; c < 10; c++) begin
      gap = 10 - c;
      r = l_tgt ^ flip_k((gap == 2 || gap == 7) ? 3 : 10 + int'($urandom_range(20, 0)));
      send(rnd_code(), r, 5, c);
    end
    send(l_tgt, l_tgt ^ flip_k(12), 5, 10);

    // every candidate at cost 40 at col 20
    l_tgt = rnd_code();
    for (int c = 0; c < 20; c++) begin
      r = (c >= 5) ? (l_tgt ^ flip_k(40)) : rnd_code();
      send(rnd_code(), r, 6, c);
    end
    send(l_tgt, l_tgt ^ flip_k(40), 6, 20);

    // random gaps and near-threshold costs, with occasional row restarts
    for (int c = 0; c < 200; c++) begin
      repeat ($urandom_range(4, 0)) @(negedge clk);
      l_tgt = rnd_code();
      r = ($urandom_range(1, 0) == 1) ? (l_tgt ^ flip_k(int'($urandom_range(30, 0)))) : rnd_code();
      send(l_tgt, r, 7, (c % 50));
    end

    // reset with three pixels in flight
    for (int c = 0; c < 3; c++) send(rnd_code(), rnd_code(), 8, c + 1);
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // restart mid-row: fill starts over and history is empty
    for (int c = 3; c < 24; c++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      l_tgt = rnd_code();
      send(l_tgt, l_tgt ^ flip_k(int'($urandom_range(25, 0))), 9, c);
    end

    repeat (LATENCY + 10) @(negedge clk);
    check("drain_pending", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
